// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller: FSM state
// encoding, MDU occupancy defaults and the source-register match helper.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_STALL    = 2'd1,
      ST_MDU_WAIT = 2'd2
   } state_t;

   localparam int MUL_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF = 32;
   localparam int MDU_CNT_W      = 6;

   // $0 never carries a dependency, so it can never match.
   function automatic logic src_match(input logic [4:0] a,
                                      input logic [4:0] rs, input logic uses_rs,
                                      input logic [4:0] rt, input logic uses_rt);
      return (a != 5'd0) && ((uses_rs && (a == rs)) || (uses_rt && (a == rt)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller; master drives the
// pipeline status, slave (the controller) returns stall/flush controls.
interface hazard_ctrl_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       id_is_branch;
   logic       id_is_mdu;
   logic       id_reads_hilo;
   logic       ex_reg_write;
   logic       ex_mem_read;
   logic [4:0] ex_write_addr;
   logic       mem_mem_read;
   logic [4:0] mem_write_addr;
   logic       branch_taken;
   logic       jump;
   logic       mdu_start;
   logic       mdu_is_div;
   logic       pc_stall;
   logic       if_id_stall;
   logic       id_ex_bubble;
   logic       if_id_flush;
   logic       mdu_busy;
   logic [1:0] state;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_is_mdu,
             id_reads_hilo, ex_reg_write, ex_mem_read, ex_write_addr,
             mem_mem_read, mem_write_addr, branch_taken, jump, mdu_start,
             mdu_is_div,
      input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, mdu_busy, state
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_is_mdu,
             id_reads_hilo, ex_reg_write, ex_mem_read, ex_write_addr,
             mem_mem_read, mem_write_addr, branch_taken, jump, mdu_start,
             mdu_is_div,
      output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, mdu_busy, state
   );
endinterface

// File: rtl/mdu_timer.sv
// Occupancy counter for the multi-cycle multiply/divide unit: busy for exactly
// 'length' cycles after a load, count runs length-1 down to 0.
module mdu_timer
   import hazard_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [MDU_CNT_W-1:0] length,
   output logic [MDU_CNT_W-1:0] count,
   output logic                 busy
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, matching the hardware it describes.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         busy  <= 1'b0;
      end else if (load) begin
         count <= MDU_CNT_W'(length - 1'b1);
         busy  <= 1'b1;
      end else if (busy) begin
         if (count == '0) busy  <= 1'b0;
         else             count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard controller with optional MDU interlock,
// enabled by defining HAZARD_MDU_INTERLOCK_EN.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);

   state_t               state_q, state_d;
   logic [1:0]           stall_cnt_q, stall_cnt_d;
   logic [1:0]           need;
   logic                 stall_all;
   logic                 mdu_load;
   logic                 mdu_busy_q;
   logic [MDU_CNT_W-1:0] mdu_cnt;

`ifdef HAZARD_MDU_INTERLOCK_EN
   localparam bit MDU_EN = 1'b1;

   mdu_timer u_mdu_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (mdu_load),
      .length (hz.mdu_is_div ? MDU_CNT_W'(DIV_CYCLES) : MDU_CNT_W'(MUL_CYCLES)),
      .count  (mdu_cnt),
      .busy   (mdu_busy_q)
   );
`else
   localparam bit MDU_EN = 1'b0;
   logic unused_mdu;

   assign mdu_busy_q = 1'b0;
   assign mdu_cnt    = '0;
   assign unused_mdu = hz.mdu_is_div ^ mdu_load ^ (MUL_CYCLES != DIV_CYCLES);
`endif

   // Stall length required by the instruction in ID (0, 1 or 2 cycles).
   always_comb begin
      need = 2'd0;
      if (hz.ex_mem_read && src_match(hz.ex_write_addr, hz.id_rs, hz.id_uses_rs,
                                      hz.id_rt, hz.id_uses_rt))
         need = hz.id_is_branch ? 2'd2 : 2'd1;
      else if (hz.ex_reg_write && hz.id_is_branch &&
               src_match(hz.ex_write_addr, hz.id_rs, hz.id_uses_rs, hz.id_rt, hz.id_uses_rt))
         need = 2'd1;
      else if (hz.mem_mem_read && hz.id_is_branch &&
               src_match(hz.mem_write_addr, hz.id_rs, hz.id_uses_rs, hz.id_rt, hz.id_uses_rt))
         need = 2'd1;
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a value held and infer a latch.
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      stall_all   = 1'b0;
      mdu_load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            mdu_load = MDU_EN && hz.mdu_start && !mdu_busy_q;
            if (need != 2'd0) begin
               stall_all   = 1'b1;
               stall_cnt_d = need - 2'd1;
            end
            if (need == 2'd2)  state_d = ST_STALL;
            else if (mdu_load) state_d = ST_MDU_WAIT;
         end
         ST_STALL: begin
            stall_all   = 1'b1;
            stall_cnt_d = stall_cnt_q - 2'd1;
            if (stall_cnt_q <= 2'd1)
               state_d = (mdu_busy_q && mdu_cnt != '0) ? ST_MDU_WAIT : ST_IDLE;
         end
         ST_MDU_WAIT: begin
            if (hz.id_reads_hilo || hz.id_is_mdu) stall_all = 1'b1;
            if (need != 2'd0) begin
               stall_all   = 1'b1;
               stall_cnt_d = need - 2'd1;
            end
            if (need == 2'd2)        state_d = ST_STALL;
            else if (mdu_cnt == '0)  state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         stall_cnt_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Outputs are forced low for the whole time rst is held, not just after the edge.
   assign hz.pc_stall     = !rst && stall_all;
   assign hz.if_id_stall  = !rst && stall_all;
   assign hz.id_ex_bubble = !rst && stall_all;
   assign hz.if_id_flush  = !rst && (hz.branch_taken || hz.jump) && !stall_all;
   assign hz.mdu_busy     = !rst && mdu_busy_q;
   assign hz.state        = rst ? ST_IDLE : state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: stimulus pushes expected outputs into
// a scoreboard queue, an independent monitor pops and compares each cycle.
module tb_hazard_ctrl;

   typedef struct {
      string      name;
      logic [6:0] exp;  // {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, mdu_busy, state[1:0]}
   } exp_t;

   localparam logic [6:0] E_IDLE  = 7'b000_0_0_00;
   localparam logic [6:0] E_STALL = 7'b111_0_0_00;
   localparam logic [6:0] E_STL2  = 7'b111_0_0_01;
   localparam logic [6:0] E_FLUSH = 7'b000_1_0_00;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   hazard_ctrl_if hif();

   hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif.slave)
   );

   always #5 clk = ~clk;

   task automatic clr();
      hif.id_rs = 5'd0;          hif.id_rt = 5'd0;
      hif.id_uses_rs = 1'b0;     hif.id_uses_rt = 1'b0;
      hif.id_is_branch = 1'b0;   hif.id_is_mdu = 1'b0;
      hif.id_reads_hilo = 1'b0;  hif.ex_reg_write = 1'b0;
      hif.ex_mem_read = 1'b0;    hif.ex_write_addr = 5'd0;
      hif.mem_mem_read = 1'b0;   hif.mem_write_addr = 5'd0;
      hif.branch_taken = 1'b0;   hif.jump = 1'b0;
      hif.mdu_start = 1'b0;      hif.mdu_is_div = 1'b0;
   endtask

   // ID/EX holds lw rd
   task automatic ex_load(input logic [4:0] rd);
      hif.ex_mem_read = 1'b1; hif.ex_reg_write = 1'b1; hif.ex_write_addr = rd;
   endtask

   task automatic id_src(input logic [4:0] rs, input logic [4:0] rt, input logic br);
      hif.id_rs = rs; hif.id_uses_rs = 1'b1;
      hif.id_rt = rt; hif.id_uses_rt = 1'b1;
      hif.id_is_branch = br;
   endtask

   // Records the expectation for the current cycle, then advances one clock.
   task automatic cyc(input string nm, input logic [6:0] e);
      exp_t x;
      x.name = nm;
      x.exp  = e;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [6:0] got, input logic [6:0] e);
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b (stall3 flush busy state)", nm, got, e);
      end
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            check(x.name, {hif.pc_stall, hif.if_id_stall, hif.id_ex_bubble,
                           hif.if_id_flush, hif.mdu_busy, hif.state}, x.exp);
         end
      end
   end

   initial begin : stimulus
      clr();
      @(posedge clk);
      #1;

      // Reset with a live hazard on the inputs: outputs must stay low.
      ex_load(5'd8); id_src(5'd8, 5'd9, 1'b1);
      cyc("rst_hazard_a", E_IDLE);
      cyc("rst_hazard_b", E_IDLE);
      rst = 1'b0; clr();
      cyc("idle", E_IDLE);

      // lw $8 ; add uses $8 -> one-cycle stall
      ex_load(5'd8); id_src(5'd8, 5'd3, 1'b0);
      cyc("loaduse_c1", E_STALL);
      clr(); hif.mem_mem_read = 1'b1; hif.mem_write_addr = 5'd8; id_src(5'd8, 5'd3, 1'b0);
      cyc("loaduse_c2", E_IDLE);

      // lw $8 ; beq $8,$9 -> two-cycle stall, STALL visible on cycle 2, then flush
      clr(); ex_load(5'd8); id_src(5'd8, 5'd9, 1'b1);
      cyc("ldbr_c1", E_STALL);
      clr(); hif.mem_mem_read = 1'b1; hif.mem_write_addr = 5'd8; id_src(5'd8, 5'd9, 1'b1);
      hif.branch_taken = 1'b1;
      cyc("ldbr_c2", E_STL2);
      clr(); id_src(5'd8, 5'd9, 1'b1); hif.branch_taken = 1'b1;
      cyc("ldbr_c3_flush", E_FLUSH);

      // lw $0 ; use $0 -> no stall, jump flushes
      clr(); ex_load(5'd0); id_src(5'd0, 5'd0, 1'b1); hif.jump = 1'b1;
      cyc("zero_reg_jump", E_FLUSH);

      // load-use with branch_taken in the same cycle -> stall, no flush
      clr(); ex_load(5'd8); id_src(5'd4, 5'd8, 1'b0); hif.branch_taken = 1'b1;
      cyc("stall_blocks_flush", E_STALL);

      // rs/rt match ignored when the source is not read
      clr(); ex_load(5'd8); hif.id_rs = 5'd8; hif.id_rt = 5'd8;
      cyc("unused_src", E_IDLE);

      // ALU result in EX: only branches stall
      clr(); hif.ex_reg_write = 1'b1; hif.ex_write_addr = 5'd5; id_src(5'd5, 5'd1, 1'b0);
      cyc("alu_ex_nonbranch", E_IDLE);
      hif.id_is_branch = 1'b1;
      cyc("alu_ex_branch", E_STALL);

      // load in MEM feeding a branch
      clr(); hif.mem_mem_read = 1'b1; hif.mem_write_addr = 5'd7; id_src(5'd2, 5'd7, 1'b1);
      cyc("mem_load_branch", E_STALL);
      clr(); hif.mem_mem_read = 1'b1; hif.mem_write_addr = 5'd7; id_src(5'd2, 5'd7, 1'b0);
      cyc("mem_load_nonbranch", E_IDLE);

      // Back-to-back: 2-cycle hazard followed immediately by a 1-cycle one
      clr(); ex_load(5'd8); id_src(5'd8, 5'd9, 1'b1);
      cyc("b2b_c1", E_STALL);
      cyc("b2b_c2", E_STL2);
      clr(); hif.ex_reg_write = 1'b1; hif.ex_write_addr = 5'd9; id_src(5'd8, 5'd9, 1'b1);
      cyc("b2b_c3", E_STALL);
      clr();
      cyc("b2b_c4", E_IDLE);

      // Reset pulsed in cycle 1 of STALL aborts the stall
      ex_load(5'd8); id_src(5'd8, 5'd9, 1'b1);
      cyc("rststall_c1", E_STALL);
      rst = 1'b1;
      cyc("rststall_rst", E_IDLE);
      rst = 1'b0; clr();
      cyc("rststall_after_a", E_IDLE);
      cyc("rststall_after_b", E_IDLE);

`ifdef HAZARD_MDU_INTERLOCK_EN
      // div start, mfhi in ID: 32 stall cycles while busy, then mfhi proceeds
      clr(); hif.mdu_start = 1'b1; hif.mdu_is_div = 1'b1;
      cyc("div_start", E_IDLE);
      clr(); hif.id_reads_hilo = 1'b1;
      for (int i = 1; i <= 32; i++) cyc($sformatf("div_wait_%0d", i), 7'b111_0_1_10);
      cyc("div_done_mfhi", E_IDLE);

      // mult: independent instructions run; a second start while busy is ignored
      clr(); hif.mdu_start = 1'b1;
      cyc("mul_start", E_IDLE);
      clr();
      cyc("mul_busy_1", 7'b000_0_1_10);
      hif.mdu_start = 1'b1; hif.mdu_is_div = 1'b1;
      cyc("mul_busy_2_restart", 7'b000_0_1_10);
      clr();
      cyc("mul_busy_3", 7'b000_0_1_10);
      cyc("mul_busy_4", 7'b000_0_1_10);
      cyc("mul_done", E_IDLE);
`else
      // Interlock disabled: MDU controls have no effect
      clr(); hif.mdu_start = 1'b1; hif.mdu_is_div = 1'b1;
      cyc("mdu_off_start", E_IDLE);
      clr(); hif.id_reads_hilo = 1'b1; hif.id_is_mdu = 1'b1;
      cyc("mdu_off_mfhi", E_IDLE);
      cyc("mdu_off_mfhi_b", E_IDLE);
`endif

      clr();
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
